// File: rtl/reg_window_file_if.sv
// Spill/fill handshake between the windowed register file and its backing memory stack.
// master = register file side, slave = memory side.
interface reg_window_file_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             spill_valid;
  logic             spill_ready;
  logic [WIDTH-1:0] spill_data;
  logic             fill_req;
  logic             fill_valid;
  logic [WIDTH-1:0] fill_data;

  modport master (
    output spill_valid, spill_data, fill_req,
    input  spill_ready, fill_valid, fill_data
  );

  modport slave (
    input  spill_valid, spill_data, fill_req,
    output spill_ready, fill_valid, fill_data
  );
endinterface

// File: rtl/reg_window_file.sv
// Windowed register file with call/return window push/pop.
// The oldest window is spilled to, and filled back from, an external stack when physical windows run out.
module reg_window_file #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NREGS     = 8,
  parameter int unsigned NWIN      = 4,
  parameter int unsigned MAX_DEPTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [$clog2(NREGS)-1:0]          selA,
  input  logic [$clog2(NREGS)-1:0]          selB,
  output logic [WIDTH-1:0]                  outA,
  output logic [WIDTH-1:0]                  outB,
  output logic [WIDTH*NREGS-1:0]            outView,
  input  logic [WIDTH-1:0]                  in,
  input  logic                              load_L,
  input  logic [1:0]                        win_op,
  output logic                              busy,
  reg_window_file_if.master                 mem,
  output logic [$clog2(MAX_DEPTH+1)-1:0]    depth,
  output logic                              err
);

  localparam int unsigned SW = $clog2(NREGS);
  localparam int unsigned BW = SW + 1;
  localparam int unsigned WW = $clog2(NWIN);
  localparam int unsigned RW = $clog2(NWIN + 1);
  localparam int unsigned DW = $clog2(MAX_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SPILL = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  logic [WIDTH-1:0] regs_q [NWIN][NREGS];

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] cwp_q, cwp_d;
  logic [RW-1:0] res_q, res_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          err_q, err_d;
  logic          busy_q, spill_valid_q, fill_req_q;

  logic [WW-1:0]    cwp_nxt, cwp_prv;
  logic             wr_en, clr_en;
  logic [WW-1:0]    wr_win, clr_win;
  logic [SW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  assign cwp_nxt = (cwp_q == WW'(NWIN - 1)) ? '0 : cwp_q + WW'(1);
  assign cwp_prv = (cwp_q == '0) ? WW'(NWIN - 1) : cwp_q - WW'(1);

  assign outA = regs_q[cwp_q][selA];
  assign outB = regs_q[cwp_q][selB];

  for (genvar k = 0; k < NREGS; k++) begin : g_view
    assign outView[k*WIDTH +: WIDTH] = regs_q[cwp_q][k];
  end

  // The spill victim is always the window just above cwp.
  assign mem.spill_data  = regs_q[cwp_nxt][beat_q[SW-1:0]];
  assign mem.spill_valid = spill_valid_q;
  assign mem.fill_req    = fill_req_q;
  assign busy            = busy_q;
  assign depth           = depth_q;
  assign err             = err_q;

  // Next-state, window pointer and register-array write control.
  always_comb begin
    state_d = state_q;
    cwp_d   = cwp_q;
    res_d   = res_q;
    depth_d = depth_q;
    beat_d  = beat_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_win  = cwp_q;
    wr_idx  = selB;
    wr_data = in;
    clr_en  = 1'b0;
    clr_win = cwp_nxt;

    case (state_q)
      S_IDLE: begin
        wr_en = ~load_L;
        if (win_op == OP_PUSH) begin
          if (depth_q == DW'(MAX_DEPTH)) begin
            err_d = 1'b1;
          end else if (res_q < RW'(NWIN)) begin
            cwp_d   = cwp_nxt;
            res_d   = res_q + RW'(1);
            depth_d = depth_q + DW'(1);
            clr_en  = 1'b1;
          end else begin
            state_d = S_SPILL;
            beat_d  = '0;
          end
        end else if (win_op == OP_POP) begin
          if (depth_q == DW'(1)) begin
            err_d = 1'b1;
          end else if (res_q > RW'(1)) begin
            cwp_d   = cwp_prv;
            res_d   = res_q - RW'(1);
            depth_d = depth_q - DW'(1);
          end else begin
            state_d = S_FILL;
            beat_d  = BW'(NREGS - 1);
          end
        end
      end

      S_SPILL: begin
        // beat == NREGS is the closing cycle that performs the deferred push.
        if (beat_q == BW'(NREGS)) begin
          cwp_d   = cwp_nxt;
          depth_d = depth_q + DW'(1);
          clr_en  = 1'b1;
          state_d = S_IDLE;
        end else if (mem.spill_ready) begin
          beat_d = beat_q + BW'(1);
        end
      end

      S_FILL: begin
        if (mem.fill_valid) begin
          wr_en   = 1'b1;
          wr_win  = cwp_prv;
          wr_idx  = beat_q[SW-1:0];
          wr_data = mem.fill_data;
          if (beat_q == '0) begin
            cwp_d   = cwp_prv;
            depth_d = depth_q - DW'(1);
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q - BW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cwp_q         <= '0;
      res_q         <= RW'(1);
      depth_q       <= DW'(1);
      beat_q        <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      spill_valid_q <= 1'b0;
      fill_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cwp_q         <= cwp_d;
      res_q         <= res_d;
      depth_q       <= depth_d;
      beat_q        <= beat_d;
      err_q         <= err_d;
      busy_q        <= (state_d != S_IDLE);
      spill_valid_q <= (state_d == S_SPILL) && (beat_d != BW'(NREGS));
      fill_req_q    <= (state_d == S_FILL);
    end
  end

  // Register array: window clear and single-register write never target the same window.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned w = 0; w < NWIN; w++) begin
        for (int unsigned r = 0; r < NREGS; r++) begin
          regs_q[w][r] <= '0;
        end
      end
    end else begin
      if (clr_en) begin
        for (int unsigned r = 0; r < NREGS; r++) begin
          regs_q[clr_win][r] <= '0;
        end
      end
      if (wr_en) begin
        regs_q[wr_win][wr_idx] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_window_file.sv
// Scoreboard bench for reg_window_file: stimulus queues expectations, negedge monitors pop and compare.
module tb_reg_window_file;

  localparam int unsigned W  = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned NW = 2;
  localparam int unsigned MD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    selA, selB;
  logic [15:0]   outA, outB, din;
  logic [127:0]  outView;
  logic          load_L;
  logic [1:0]    win_op;
  logic          busy;
  logic [2:0]    depth;
  logic          err;

  always #5 clock = ~clock;

  reg_window_file_if #(.WIDTH(W)) mem_if ();

  reg_window_file #(.WIDTH(W), .NREGS(NR), .NWIN(NW), .MAX_DEPTH(MD)) dut (
    .clock  (clock),
    .reset  (reset),
    .selA   (selA),
    .selB   (selB),
    .outA   (outA),
    .outB   (outB),
    .outView(outView),
    .in     (din),
    .load_L (load_L),
    .win_op (win_op),
    .busy   (busy),
    .mem    (mem_if),
    .depth  (depth),
    .err    (err)
  );

  typedef struct {
    int          due;
    int          id;
    logic [15:0] a;
    logic [15:0] v3;
    int          d;
    bit          e;
    bit          b;
  } st_exp_t;

  typedef struct {
    int len;
    int sp;
    int fl;
  } busy_exp_t;

  st_exp_t     q_st[$];
  logic [15:0] q_sp[$];
  busy_exp_t   q_busy[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int chk_id = 0;
  int blen   = 0;
  int bsp    = 0;
  int bfl    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void cmp(string nm, int id, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s #%0d got %h want %h", nm, id, got, want);
    end
  endfunction

  function automatic void unexpected(string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endfunction

  // State monitor
  always @(negedge clock) begin
    st_exp_t x;
    if (q_st.size() > 0 && q_st[0].due == cyc) begin
      x = q_st.pop_front();
      cmp("outA",    x.id, 32'(outA), 32'(x.a));
      cmp("view3",   x.id, 32'(outView[63:48]), 32'(x.v3));
      cmp("depth",   x.id, 32'(depth), x.d);
      cmp("err",     x.id, 32'(err), 32'(x.e));
      cmp("busy",    x.id, 32'(busy), 32'(x.b));
    end
  end

  // Spill beat monitor: data must match the queued beat, also while stalled
  always @(negedge clock) begin
    if (!reset && mem_if.spill_valid) begin
      if (q_sp.size() == 0) begin
        unexpected("spill_unexpected");
      end else begin
        cmp("spill_data", checks, 32'(mem_if.spill_data), 32'(q_sp[0]));
        if (mem_if.spill_ready) void'(q_sp.pop_front());
      end
    end
  end

  // Busy episode monitor
  always @(negedge clock) begin
    busy_exp_t b;
    if (busy) begin
      blen++;
      if (!reset && mem_if.spill_valid && mem_if.spill_ready) bsp++;
      if (!reset && mem_if.fill_req && mem_if.fill_valid) bfl++;
    end else if (blen > 0) begin
      if (q_busy.size() == 0) begin
        unexpected("busy_unexpected");
      end else begin
        b = q_busy.pop_front();
        cmp("busy_len",   blen, blen, b.len);
        cmp("busy_spill", blen, bsp,  b.sp);
        cmp("busy_fill",  blen, bfl,  b.fl);
      end
      blen = 0;
      bsp  = 0;
      bfl  = 0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_st(logic [15:0] a, logic [15:0] v3, int d, bit e, bit b);
    st_exp_t x;
    x.due = cyc;
    x.id  = chk_id;
    x.a   = a;
    x.v3  = v3;
    x.d   = d;
    x.e   = e;
    x.b   = b;
    chk_id++;
    q_st.push_back(x);
    step();
  endtask

  task automatic write_win(logic [15:0] base);
    for (int k = 0; k < NR; k++) begin
      load_L = 1'b0;
      selB   = 3'(k);
      din    = base + 16'(k);
      step();
    end
    load_L = 1'b1;
  endtask

  task automatic do_op(logic [1:0] op);
    win_op = op;
    step();
    win_op = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    if (busy) unexpected("busy_timeout");
  endtask

  task automatic exp_spill(logic [15:0] base, int n);
    for (int k = 0; k < n; k++) q_sp.push_back(base + 16'(k));
  endtask

  task automatic exp_busy(int len, int sp, int fl);
    busy_exp_t b;
    b.len = len;
    b.sp  = sp;
    b.fl  = fl;
    q_busy.push_back(b);
  endtask

  initial begin
    reset  = 1'b1;
    selA   = '0;
    selB   = '0;
    din    = '0;
    load_L = 1'b1;
    win_op = 2'b00;
    mem_if.spill_ready = 1'b1;
    mem_if.fill_valid  = 1'b1;
    mem_if.fill_data   = '0;
    step();
    step();
    reset = 1'b0;

    // 1: reset state, write and read back
    selA = 3'd3;
    expect_st(16'h0000, 16'h0000, 1, 1'b0, 1'b0);
    load_L = 1'b0; selB = 3'd3; din = 16'h1234;
    step();
    load_L = 1'b1;
    expect_st(16'h1234, 16'h1234, 1, 1'b0, 1'b0);

    // 2: write with push lands in old window; pop returns it
    load_L = 1'b0; selB = 3'd3; din = 16'hAAAA;
    do_op(2'b01);
    load_L = 1'b1;
    expect_st(16'h0000, 16'h0000, 2, 1'b0, 1'b0);
    do_op(2'b10);
    expect_st(16'hAAAA, 16'hAAAA, 1, 1'b0, 1'b0);

    // 3: spill with a 3-cycle stall on beat 2
    write_win(16'h0100);
    expect_st(16'h0103, 16'h0103, 1, 1'b0, 1'b0);
    do_op(2'b01);
    expect_st(16'h0000, 16'h0000, 2, 1'b0, 1'b0);
    exp_spill(16'h0100, 8);
    exp_busy(12, 8, 0);
    do_op(2'b01);
    step();
    step();
    mem_if.spill_ready = 1'b0;
    repeat (3) step();
    mem_if.spill_ready = 1'b1;
    wait_idle();
    expect_st(16'h0000, 16'h0000, 3, 1'b0, 1'b0);

    // 4: pop twice, second pop fills in reverse order
    do_op(2'b10);
    expect_st(16'h0000, 16'h0000, 2, 1'b0, 1'b0);
    exp_busy(8, 0, 8);
    do_op(2'b10);
    for (int k = NR - 1; k >= 0; k--) begin
      mem_if.fill_data = 16'h0100 + 16'(k);
      step();
    end
    mem_if.fill_data = '0;
    wait_idle();
    for (int k = 0; k < NR; k++) begin
      selA = 3'(k);
      expect_st(16'h0100 + 16'(k), 16'h0103, 1, 1'b0, 1'b0);
    end

    // 5: underflow, then push to max depth and overflow
    do_op(2'b10);
    selA = 3'd0;
    expect_st(16'h0100, 16'h0103, 1, 1'b1, 1'b0);
    do_op(2'b01);
    selA = 3'd3;
    expect_st(16'h0000, 16'h0000, 2, 1'b1, 1'b0);
    exp_spill(16'h0100, 8);
    exp_busy(9, 8, 0);
    do_op(2'b01);
    wait_idle();
    expect_st(16'h0000, 16'h0000, 3, 1'b1, 1'b0);
    for (int k = 0; k < NR; k++) q_sp.push_back(16'h0000);
    exp_busy(9, 8, 0);
    do_op(2'b01);
    wait_idle();
    expect_st(16'h0000, 16'h0000, 4, 1'b1, 1'b0);
    do_op(2'b01);
    expect_st(16'h0000, 16'h0000, 4, 1'b1, 1'b0);

    // 6: reset mid-spill aborts and clears err
    reset = 1'b1;
    step();
    reset = 1'b0;
    do_op(2'b10);
    selA = 3'd0;
    expect_st(16'h0000, 16'h0000, 1, 1'b1, 1'b0);
    write_win(16'h0200);
    do_op(2'b01);
    selA = 3'd3;
    expect_st(16'h0000, 16'h0000, 2, 1'b1, 1'b0);
    exp_spill(16'h0200, 4);
    exp_busy(5, 4, 0);
    do_op(2'b01);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    selA = 3'd0;
    expect_st(16'h0000, 16'h0000, 1, 1'b0, 1'b0);
    for (int k = 0; k < NR; k++) begin
      selA = 3'(k);
      expect_st(16'h0000, 16'h0000, 1, 1'b0, 1'b0);
    end

    repeat (3) step();
    cmp("spill_q_left", 0, 32'(q_sp.size()), 32'd0);
    cmp("busy_q_left",  0, 32'(q_busy.size()), 32'd0);
    cmp("state_q_left", 0, 32'(q_st.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
